// File: rtl/out_stream_buf.sv
// Ping-pong tile result buffer that drains completed tiles as an AXI-Stream master.
// Optional OUTBUF_RELU_EN: clamp negative results to zero on the stream path only.
module out_stream_buf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic          in_v,
  input  logic [AW-1:0] in_a,
  input  logic [DW-1:0] in_d,
  input  logic          in_fin,
  input  logic          in_last,
  output logic          buf_busy,
  output logic          ovf,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tlast
);

  localparam int unsigned N = 1 << AW;

  logic [DW-1:0] mem [2][N];

  logic          wb_q, wb_d, rb_q, rb_d;
  logic [1:0]    full_q, full_d, lflag_q, lflag_d;
  logic          busy_q, busy_d, ovf_q, ovf_d;
  logic          ib_q, ib_d;
  logic [AW-1:0] ia_q, ia_d;
  logic          rd_v_q, rd_v_d, rd_end_q, rd_end_d, rd_last_q, rd_last_d;
  logic [DW-1:0] rd_data_q, rd_val;
  logic          out_v_q, out_v_d, out_last_q, out_last_d, out_end_q, out_end_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          sk_v_q, sk_v_d, sk_last_q, sk_last_d, sk_end_q, sk_end_d;
  logic [DW-1:0] sk_data_q, sk_data_d;

  logic          pop, iss, wr_en, credit;
  logic [1:0]    occ;

  // Read value for the issue pointer, with optional ReLU clamp.
  always_comb begin
    rd_val = mem[ib_q][ia_q];
`ifdef OUTBUF_RELU_EN
    if (rd_val[DW-1]) rd_val = '0;
`endif
  end

  always_comb begin
    wb_d       = wb_q;
    rb_d       = rb_q;
    full_d     = full_q;
    lflag_d    = lflag_q;
    ovf_d      = ovf_q;
    ib_d       = ib_q;
    ia_d       = ia_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_end_d  = out_end_q;
    sk_v_d     = sk_v_q;
    sk_data_d  = sk_data_q;
    sk_last_d  = sk_last_q;
    sk_end_d   = sk_end_q;

    pop    = out_v_q & m_axis_tready;
    wr_en  = run & in_v & ~busy_q;
    // Never let output reg + skid + in-flight read exceed two entries.
    occ    = 2'(out_v_q) + 2'(sk_v_q) + 2'(rd_v_q);
    credit = (occ <= (2'd1 + 2'(pop)));
    iss    = run & full_q[ib_q] & credit;

    if (in_fin && !busy_q) begin
      full_d[wb_q]  = 1'b1;
      lflag_d[wb_q] = in_last;
      wb_d          = ~wb_q;
    end
    if ((in_v || in_fin) && busy_q) ovf_d = 1'b1;

    if (pop && out_end_q) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
    busy_d = full_d[0] & full_d[1];

    rd_v_d    = iss;
    rd_end_d  = iss & (&ia_q);
    rd_last_d = iss & (&ia_q) & lflag_q[ib_q];
    if (iss) begin
      ia_d = ia_q + AW'(1);
      if (&ia_q) ib_d = ~ib_q;
    end

    // Output register refills from skid first, then from the RAM read stage.
    if (!out_v_q || pop) begin
      if (sk_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = sk_data_q;
        out_last_d = sk_last_q;
        out_end_d  = sk_end_q;
        sk_v_d     = rd_v_q;
        if (rd_v_q) begin
          sk_data_d = rd_data_q;
          sk_last_d = rd_last_q;
          sk_end_d  = rd_end_q;
        end
      end else begin
        out_v_d = rd_v_q;
        sk_v_d  = 1'b0;
        if (rd_v_q) begin
          out_data_d = rd_data_q;
          out_last_d = rd_last_q;
          out_end_d  = rd_end_q;
        end else begin
          out_last_d = 1'b0;
          out_end_d  = 1'b0;
        end
      end
    end else if (rd_v_q) begin
      sk_v_d    = 1'b1;
      sk_data_d = rd_data_q;
      sk_last_d = rd_last_q;
      sk_end_d  = rd_end_q;
    end

    if (!run) begin
      wb_d       = 1'b0;
      rb_d       = 1'b0;
      full_d     = '0;
      lflag_d    = '0;
      busy_d     = 1'b0;
      ovf_d      = 1'b0;
      ib_d       = 1'b0;
      ia_d       = '0;
      rd_v_d     = 1'b0;
      rd_end_d   = 1'b0;
      rd_last_d  = 1'b0;
      out_v_d    = 1'b0;
      out_data_d = '0;
      out_last_d = 1'b0;
      out_end_d  = 1'b0;
      sk_v_d     = 1'b0;
      sk_data_d  = '0;
      sk_last_d  = 1'b0;
      sk_end_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      full_q     <= '0;
      lflag_q    <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ib_q       <= 1'b0;
      ia_q       <= '0;
      rd_v_q     <= 1'b0;
      rd_end_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_end_q  <= 1'b0;
      sk_v_q     <= 1'b0;
      sk_data_q  <= '0;
      sk_last_q  <= 1'b0;
      sk_end_q   <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      full_q     <= full_d;
      lflag_q    <= lflag_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      ib_q       <= ib_d;
      ia_q       <= ia_d;
      rd_v_q     <= rd_v_d;
      rd_end_q   <= rd_end_d;
      rd_last_q  <= rd_last_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_end_q  <= out_end_d;
      sk_v_q     <= sk_v_d;
      sk_data_q  <= sk_data_d;
      sk_last_q  <= sk_last_d;
      sk_end_q   <= sk_end_d;
    end
  end

  // Tile storage and registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wb_q][in_a] <= in_d;
    if (iss)   rd_data_q <= rd_val;
  end

  assign buf_busy      = busy_q;
  assign ovf           = ovf_q;
  assign m_axis_tvalid = out_v_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_out_stream_buf.sv
// Scoreboard bench for out_stream_buf: expected beats queued at tile completion,
// popped and compared by a monitor on every accepted stream handshake.
module tb_out_stream_buf;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned N  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          in_v = 1'b0;
  logic [AW-1:0] in_a = '0;
  logic [DW-1:0] in_d = '0;
  logic          in_fin = 1'b0;
  logic          in_last = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          buf_busy, ovf, m_axis_tvalid, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;

  out_stream_buf #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .in_v(in_v), .in_a(in_a), .in_d(in_d), .in_fin(in_fin), .in_last(in_last),
    .buf_busy(buf_busy), .ovf(ovf),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model [2][N];
  int            wb_m = 0;
  int            checks = 0;
  int            errors = 0;
  int            beats = 0;
  bit            stab_en = 1'b1;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;
  bit            busy_watch = 1'b0;
  bit            busy_seen = 1'b0;

  function automatic logic [DW-1:0] exp_val(input logic [DW-1:0] d);
`ifdef OUTBUF_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input bit ok);
    in_v = 1'b1;
    in_a = AW'(a);
    in_d = d;
    tick();
    in_v = 1'b0;
    if (ok) model[wb_m][a] = d;
  endtask

  task automatic fin(input bit last, input bit ok);
    beat_t e;
    in_fin  = 1'b1;
    in_last = last;
    tick();
    in_fin  = 1'b0;
    in_last = 1'b0;
    if (ok) begin
      for (int i = 0; i < N; i++) begin
        e.d = exp_val(model[wb_m][i]);
        e.l = last && (i == N - 1);
        exp_q.push_back(e);
      end
      wb_m ^= 1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: compares every accepted beat and checks stall stability.
  always @(negedge clk) begin
    beat_t e;
    if (stab_en && prev_stall) begin
      checks++;
      if (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b d=0x%0h l=%0b required v=1 d=0x%0h l=%0b",
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got 0x%0h required no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
          errors++;
          $display("FAIL beat: got d=0x%0h l=%0b required d=0x%0h l=%0b",
                   m_axis_tdata, m_axis_tlast, e.d, e.l);
        end
      end
    end
    prev_stall = stab_en && m_axis_tvalid && !m_axis_tready;
    prev_d     = m_axis_tdata;
    prev_l     = m_axis_tlast;
    if (busy_watch && buf_busy) busy_seen = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int vlen;
    int b0;
    int n;

    // Reset state
    m_axis_tready = 1'b1;
    run = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_busy", 32'(buf_busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    tick();

    // T1: single tile, d=3a, latency of first beat
    for (int a = 0; a < N; a++) wr(a, 32'(3 * a), 1'b1);
    fin(1'b1, 1'b1);
    check("t1_lat0", 32'(m_axis_tvalid), 32'd0);
    tick();
    check("t1_lat1", 32'(m_axis_tvalid), 32'd0);
    tick();
    check("t1_lat2", 32'(m_axis_tvalid), 32'd1);
    check("t1_first", m_axis_tdata, 32'd0);
    wait_drain("t1_drain", 60);

    // T2: two tiles, second in_fin coincides with first tile's final accept
    busy_seen  = 1'b0;
    busy_watch = 1'b1;
    for (int a = 0; a < N; a++) wr(a, 32'(100 + a), 1'b1);
    fin(1'b0, 1'b1);
    tick();
    for (int a = 0; a < N; a++) wr(a, 32'(200 + a), 1'b1);
    fin(1'b1, 1'b1);
    wait_drain("t2_drain", 80);
    busy_watch = 1'b0;
    check("t2_busy_seen", 32'(busy_seen), 32'd0);
    check("t2_ovf", 32'(ovf), 32'd0);

    // T3: tready pattern 1,0,0 repeating
    for (int a = 0; a < N; a++) wr(a, 32'(7 * a + 1), 1'b1);
    fin(1'b0, 1'b1);
    for (int p = 0; p < 200 && (exp_q.size() != 0 || m_axis_tvalid); p++) begin
      m_axis_tready = (p % 3 == 0);
      tick();
    end
    m_axis_tready = 1'b1;
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // T4: fill both banks while stalled, overflow write, then zero-bubble drain
    m_axis_tready = 1'b0;
    for (int a = 0; a < N; a++) wr(a, 32'(1000 + a), 1'b1);
    fin(1'b0, 1'b1);
    for (int a = 0; a < N; a++) wr(a, 32'(2000 + a), 1'b1);
    fin(1'b1, 1'b1);
    check("t4_busy", 32'(buf_busy), 32'd1);
    check("t4_ovf_pre", 32'(ovf), 32'd0);
    wr(0, 32'h0000DEAD, 1'b0);
    check("t4_ovf", 32'(ovf), 32'd1);
    m_axis_tready = 1'b1;
    vlen = 0;
    for (int k = 0; k < 80; k++) begin
      if (m_axis_tvalid) vlen++;
      else if (vlen > 0) break;
      tick();
    end
    check("t4_run_len", 32'(vlen), 32'd32);
    wait_drain("t4_drain", 20);
    check("t4_ovf_sticky", 32'(ovf), 32'd1);
    check("t4_busy_end", 32'(buf_busy), 32'd0);

    // T5: descending write order, async reset mid-tile
    for (int a = N - 1; a >= 0; a--) wr(a, 32'(a), 1'b1);
    fin(1'b1, 1'b1);
    b0 = beats;
    n = 0;
    while (beats - b0 < 5 && n < 50) begin
      tick();
      n++;
    end
    check("t5_beats", 32'(beats - b0), 32'd5);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    wb_m = 0;
    #1;
    check("t5_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t5_rst_tdata", m_axis_tdata, 32'd0);
    check("t5_rst_ovf", 32'(ovf), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // T5b: run=0 synchronous clear with both banks full and ovf set
    m_axis_tready = 1'b0;
    for (int a = 0; a < N; a++) wr(a, 32'(50 + a), 1'b1);
    fin(1'b0, 1'b1);
    for (int a = 0; a < N; a++) wr(a, 32'(70 + a), 1'b1);
    fin(1'b0, 1'b1);
    wr(3, 32'd0, 1'b0);
    check("t5b_ovf_set", 32'(ovf), 32'd1);
    stab_en = 1'b0;
    run = 1'b0;
    check("t5b_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
    tick();
    check("t5b_ovf", 32'(ovf), 32'd0);
    check("t5b_busy", 32'(buf_busy), 32'd0);
    check("t5b_tvalid", 32'(m_axis_tvalid), 32'd0);
    exp_q.delete();
    wb_m = 0;
    run = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    stab_en = 1'b1;
    tick();
    check("t5b_idle", 32'(m_axis_tvalid), 32'd0);

    // T6: negative data through the stream path
    wr(0, 32'hFFFFFFFB, 1'b1);
    for (int a = 1; a < N; a++) wr(a, 32'(2 * a - 8), 1'b1);
    fin(1'b1, 1'b1);
    tick();
    tick();
    check("t6_tvalid", 32'(m_axis_tvalid), 32'd1);
`ifdef OUTBUF_RELU_EN
    check("t6_first", m_axis_tdata, 32'd0);
`else
    check("t6_first", m_axis_tdata, 32'hFFFFFFFB);
`endif
    wait_drain("t6_drain", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
